// File: rtl/sccb_pkg.sv
// SCCB target shared types and constants.
// The default ID is also used by the master's config ROM.
package sccb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEVADDR,
    S_ACK_DEV,
    S_REGADDR,
    S_ACK_REG,
    S_WDATA,
    S_ACK_WDATA,
    S_RDATA,
    S_RACK,
    S_IGNORE
  } sccb_state_t;

  localparam int SCCB_BITS   = 8;
  localparam int SCCB_RW_BIT = 0;

  localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;

  function automatic logic [7:0] sccb_rd_id(input logic [7:0] id);
    return id | 8'(1 << SCCB_RW_BIT);
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes sioc/siod into clk and flags clock edges
// plus START/STOP bus conditions.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sioc,
  input  logic siod_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;
  logic                   w_scl;

  // Idle bus is high; resetting to 1 avoids phantom edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], sioc};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], siod_in};
      r_scl_q    <= w_scl;
      r_sda_q    <= sda;
    end
  end

  assign w_scl     = r_scl_sync[SYNC_STAGES-1];
  assign sda       = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise  = w_scl & ~r_scl_q;
  assign scl_fall  = ~w_scl & r_scl_q;
  assign start_det = w_scl & r_sda_q & ~sda;
  assign stop_det  = w_scl & ~r_sda_q & sda;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target fronting an 8-bit addressed register file.
// Samples on sioc rise, drives siod_oe only on sioc fall.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = SCCB_DEFAULT_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [7:0] RD_ID    = sccb_rd_id(DEV_ID);
  localparam logic [2:0] LAST_BIT = 3'(SCCB_BITS - 1);

  logic        w_sda;
  logic        w_rise;
  logic        w_fall;
  logic        w_start;
  logic        w_stop;
  logic [7:0]  w_byte;

  sccb_state_t r_state,   w_state;
  logic [2:0]  r_bitcnt,  w_bitcnt;
  logic [7:0]  r_shift,   w_shift;
  logic [7:0]  r_ptr,     w_ptr;
  logic        r_oe,      w_oe;
  logic        r_busy,    w_busy;
  logic        r_wr_en,   w_wr_en;
  logic [7:0]  r_wr_addr, w_wr_addr;
  logic [7:0]  r_wr_data, w_wr_data;
  logic        r_rd_mode, w_rd_mode;
  logic        r_acked,   w_acked;

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sioc      (sioc),
    .siod_in   (siod_in),
    .sda       (w_sda),
    .scl_rise  (w_rise),
    .scl_fall  (w_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_mode <= 1'b0;
      r_acked   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_bitcnt  <= w_bitcnt;
      r_shift   <= w_shift;
      r_ptr     <= w_ptr;
      r_oe      <= w_oe;
      r_busy    <= w_busy;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_rd_mode <= w_rd_mode;
      r_acked   <= w_acked;
    end
  end

  assign w_byte = {r_shift[6:0], w_sda};

  always_comb begin
    w_state   = r_state;
    w_bitcnt  = r_bitcnt;
    w_shift   = r_shift;
    w_ptr     = r_ptr;
    w_oe      = r_oe;
    w_busy    = r_busy;
    w_wr_en   = 1'b0;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_rd_mode = r_rd_mode;
    w_acked   = r_acked;
    if (w_start) begin
      w_state  = S_DEVADDR;
      w_bitcnt = '0;
      w_busy   = 1'b1;
      w_oe     = 1'b0;
      w_acked  = 1'b0;
    end else if (w_stop) begin
      w_state = S_IDLE;
      w_busy  = 1'b0;
      w_oe    = 1'b0;
    end else begin
      unique case (r_state)
        S_DEVADDR, S_REGADDR, S_WDATA: begin
          if (w_rise) begin
            w_shift  = w_byte;
            w_bitcnt = r_bitcnt + 3'd1;
            if (r_bitcnt == LAST_BIT) begin
              if (r_state == S_DEVADDR) begin
                if (w_byte == DEV_ID) begin
                  w_state   = S_ACK_DEV;
                  w_rd_mode = 1'b0;
                end else if (w_byte == RD_ID) begin
                  w_state   = S_ACK_DEV;
                  w_rd_mode = 1'b1;
                end else begin
                  w_state = S_IGNORE;
                end
              end else if (r_state == S_REGADDR) begin
                w_ptr   = w_byte;
                w_state = S_ACK_REG;
              end else begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_ptr;
                w_wr_data = w_byte;
                w_state   = S_ACK_WDATA;
              end
            end
          end
        end
        // r_oe doubles as "ACK already driven" within a slot.
        S_ACK_DEV, S_ACK_REG, S_ACK_WDATA: begin
          if (w_fall) begin
            if (!r_oe) begin
              w_oe = 1'b1;
            end else begin
              w_oe     = 1'b0;
              w_bitcnt = '0;
              if (r_state == S_ACK_DEV && r_rd_mode) begin
                w_shift = rd_data;
                w_oe    = ~rd_data[7];
                w_state = S_RDATA;
              end else if (r_state == S_ACK_DEV) begin
                w_state = S_REGADDR;
              end else begin
                w_state = S_WDATA;
                if (r_state == S_ACK_WDATA) w_ptr = r_ptr + 8'd1;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_fall) begin
            if (r_bitcnt == LAST_BIT) begin
              w_oe     = 1'b0;
              w_bitcnt = '0;
              w_acked  = 1'b0;
              w_state  = S_RACK;
            end else begin
              w_bitcnt = r_bitcnt + 3'd1;
              w_shift  = {r_shift[6:0], 1'b0};
              w_oe     = ~r_shift[6];
            end
          end
        end
        S_RACK: begin
          if (w_rise) begin
            if (w_sda) begin
              w_state = S_IGNORE;
            end else begin
              w_ptr   = r_ptr + 8'd1;
              w_acked = 1'b1;
            end
          end else if (w_fall && r_acked) begin
            w_shift  = rd_data;
            w_oe     = ~rd_data[7];
            w_bitcnt = '0;
            w_acked  = 1'b0;
            w_state  = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign siod_oe = r_oe;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;
  assign busy    = r_busy;

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
SCCB/I2C target (slave) that answers the camera-config master's bus: it decodes device address, register sub-address and data bytes from sioc/siod, and drives ACK and read data onto siod through an open-drain enable. The block fronts an 8-bit-addressed register file. Uses: a synthesizable OV7670 register-model stand-in for board bring-up, and the loopback target in the config-path bench.

Parameters:
DEV_ID, 8'h42, 8-bit write address with LSB 0; the read address is DEV_ID|1 (8'h43).
SYNC_STAGES, 2, flops in the sioc/siod input synchronizers, minimum 2.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
sioc  in  1  SCCB clock from the master, asynchronous to clk.
siod_in  in  1  sampled SCCB data line, asynchronous.
siod_oe  out  1  1 = pull siod low (open drain); 0 = release.
wr_en  out  1  one-clk pulse: write wr_data to wr_addr.
wr_addr  out  8  register address for the write.
wr_data  out  8  register data for the write.
rd_addr  out  8  current register pointer, for combinational lookup.
rd_data  in  8  register contents at rd_addr, valid the same cycle.
busy  out  1  high from START until STOP or abort.

Behaviour:
- Reset: siod_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr (pointer)=0, busy=0, state IDLE. Reset mid-transaction releases siod immediately (next clk) and drops the transfer.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop. Event latency from a pin edge is SYNC_STAGES+1 clk. Each sioc high and low phase must last at least SYNC_STAGES+3 clk.
- START: synced siod falls while synced sioc is high. Valid in any state, including mid-byte (repeated start). Action: bit counter=0, busy=1, siod_oe=0, go to DEVADDR.
- STOP: synced siod rises while synced sioc is high. Action: go to IDLE, busy=0, siod_oe=0. The pointer is kept.
- Data bits are sampled on sioc rise, MSB first. siod_oe changes only on sioc fall, so siod never moves while sioc is high.
- States: IDLE, DEVADDR, ACK_DEV, REGADDR, ACK_REG, WDATA, ACK_WDATA, RDATA, RACK, IGNORE.
- DEVADDR: after the 8th rise, compare the byte:
  - DEV_ID: go to ACK_DEV with mode=write.
  - DEV_ID|1: go to ACK_DEV with mode=read.
  - anything else: go to IGNORE. siod_oe stays 0 until the next START.
- ACK slots: on the sioc fall after the 8th bit, set siod_oe=1. On the sioc fall after the ACK bit, set siod_oe=0, except in read mode, where the line is driven with data instead.
- Read path:
  - At the fall ending ACK_DEV in read mode: load shift register with rd_data, drive siod_oe=~bit7, enter RDATA.
  - On each following fall: drive the next bit. After bit0's fall, release the line and enter RACK.
  - RACK samples the master's bit on sioc rise. 0 (ACK): increment pointer, reload at the next fall, return to RDATA. 1 (NACK): go to IGNORE.
- Write path:
  - ACK_DEV (write mode) -> REGADDR. The byte loads the pointer, then ACK_REG.
  - ACK_REG -> WDATA. On the 8th rise: wr_addr=pointer, wr_data=byte, wr_en=1 for exactly one clk, then ACK_WDATA.
  - ACK_WDATA -> WDATA for further bytes, with pointer+1.
- Pointer increments mod 256 (8'hFF -> 8'h00).
- A write phase with only the sub-address (two bytes then STOP) sets the pointer without writing; this is the SCCB 2-phase write used before a read.
- START and a sioc edge detected in the same clk: START wins, the edge is ignored.
- A STOP or START inside a byte aborts it. No wr_en is issued for a partial byte.

Decomposition:
- Package sccb_pkg holds:
  - sccb_state_t enum (the ten states above);
  - constants SCCB_BITS=8 and SCCB_RW_BIT=0;
  - a default-ID localparam shared with the master's config ROM.
- One sub-module, sccb_line_sync: SYNC_STAGES synchronizer for sioc and siod, plus outputs scl_rise, scl_fall, start_det, stop_det.

Test Plan:
- 3-phase write 8'h42, 8'h12, 8'h80, then STOP: siod_oe=1 in all three ACK slots. Exactly one wr_en with wr_addr=8'h12, wr_data=8'h80. busy falls SYNC_STAGES+1 clk after the STOP edge.
- Wrong ID 8'h60, 8'h12, 8'h80: siod_oe stays 0 throughout, no wr_en, busy=1 until STOP.
- Write 8'h42, 8'h0A, STOP; then START, 8'h43, model returns 8'h76 at 8'h0A, master NACK: ACK on the ID byte; bits observed on siod (~siod_oe) are 0,1,1,1,0,1,1,0. Line released in the NACK slot; pointer stays 8'h0A.
- Burst write 8'h42, 8'hFE, 8'h11, 8'h22, 8'h33: three wr_en pulses with (8'hFE, 8'h11), (8'hFF, 8'h22), (8'h00, 8'h33), showing the pointer wrap.
- Repeated START after 4 bits of a data byte, followed by a full write 8'h42, 8'h05, 8'hAA: no wr_en for the partial byte; one wr_en with (8'h05, 8'hAA).
- Assert reset while siod_oe=1 during a read byte: siod_oe=0 and busy=0 within 1 clk of reset. The next valid transaction after reset is accepted normally.
